bcd_display_driver: RTL and testbench



---
 rtl/npu_display_pkg.sv | 25 ++
 rtl/bcd_add3.sv | 18 +
 rtl/bcd_display_driver.sv | 149 ++++++++++++++
 tb/tb_bcd_display_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/npu_display_pkg.sv
// npu_display_pkg: shared types and constants for the display driver.
// Holds the conversion FSM state type, default digit count, BCD nibble
// width and an elaboration-time power-of-ten helper.
package npu_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_DIGITS = 6;
  localparam int BCD_W          = 4;

  // 10^n as a 64-bit constant; only meant for elaboration-time use.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble adjust. A nibble of 5 or more gets 3
// added so that the following left shift carries into the next digit.
module bcd_add3
  import npu_display_pkg::*;
(
  input  logic [BCD_W-1:0] in,
  output logic [BCD_W-1:0] out
);

  // Add-3 correction applied ahead of each shift step.
  always_comb begin
    out = in;
    if (in >= BCD_W'(5)) begin
      out = in + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: converts an unsigned binary word into DIGITS
// decimal digit codes using an iterative double-dabble engine (one bit
// per clock). Inputs of 10^DIGITS or more are shown as raw hex nibbles
// with the overflow flag set. Outputs hold until the next conversion.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits; otherwise blank_out is constant zero and every digit is lit.
module bcd_display_driver
  import npu_display_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = DEFAULT_DIGITS
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_value,
  output logic [BCD_W*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]         blank_out,
  output logic                      overflow,
  output logic                      done
);

  localparam int F_W   = BCD_W * DIGITS;      // BCD field width
  localparam int TOT_W = F_W + BIN_W;         // {bcd, bin} shift register
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Overflow threshold; when the input range cannot reach it the compare
  // is folded to a constant zero.
  localparam logic [63:0] LIMIT  = pow10(DIGITS);
  localparam bit          CMP_EN = (BIN_W < 64) && ((64'd1 << BIN_W) > LIMIT);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [TOT_W-1:0]    shift_reg;
  logic [F_W-1:0]      hex_reg;
  logic                ovf_reg;

  logic                ovf_cmp;
  logic [F_W-1:0]      hex_in;
  logic [F_W-1:0]      bcd_adj;
  logic [TOT_W-1:0]    shift_next;
  logic [F_W-1:0]      result_next;

  assign in_ready = (state_reg == IDLE);

  // Overflow compare on the incoming value.
  generate
    if (CMP_EN) begin : g_cmp
      assign ovf_cmp = (64'(in_value) >= LIMIT);
    end else begin : g_nocmp
      assign ovf_cmp = 1'b0;
    end
  endgenerate

  // Hex fallback: low F_W bits of the input, zero-extended if narrower.
  generate
    if (BIN_W >= F_W) begin : g_hex_trunc
      assign hex_in = in_value[F_W-1:0];
    end else begin : g_hex_ext
      assign hex_in = {{(F_W - BIN_W){1'b0}}, in_value};
    end
  endgenerate

  // One add-3 adjuster per BCD digit of the shift register.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .in  (shift_reg[BIN_W + gi*BCD_W +: BCD_W]),
        .out (bcd_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Adjusted digits and remaining binary bits shift left as one word.
  assign shift_next = {bcd_adj, shift_reg[BIN_W-1:0]} << 1;

  // Value presented on the output edge: hex on overflow, BCD otherwise.
  assign result_next = ovf_reg ? hex_reg : shift_reg[TOT_W-1 -: F_W];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  // Digit i goes dark when it and every digit above it are zero; digit 0
  // always stays lit so a zero value still shows "0".
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_next[gi] = 1'b0;
      end else begin : g_upper
        assign blank_next[gi] = ~|result_next[F_W-1 : gi*BCD_W];
      end
    end
  endgenerate
`else
  assign blank_out = '0;
`endif

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      hex_reg    <= '0;
      ovf_reg    <= 1'b0;
      digits_out <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_out  <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= TOT_W'(in_value);
            cnt_reg   <= '0;
            ovf_reg   <= ovf_cmp;
            hex_reg   <= hex_in;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          digits_out <= result_next;
          overflow   <= ovf_reg;
          done       <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          blank_out  <= blank_next;
`endif
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed table-driven bench for bcd_display_driver,
// plus hand-written sequences for ignored requests and mid-conversion reset.
module tb_bcd_display_driver;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_value;
  logic [23:0] digits_out;
  logic [5:0]  blank_out;
  logic        overflow;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [19:0] value;
    logic [23:0] digits;
    logic        ovf;
    logic [5:0]  blank_lz;   // expected blank_out when leading-zero blanking is built in
  } vec_t;

  vec_t vecs [7];

  bcd_display_driver #(.BIN_W(20), .DIGITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .digits_out (digits_out),
    .blank_out  (blank_out),
    .overflow   (overflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_blank(input logic [5:0] lz);
`ifdef LEADING_ZERO_BLANK_EN
    return lz;
`else
    return lz & 6'b000000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Present one value for a single accept edge; leaves time at E0 + 1.
  task automatic start(input logic [19:0] v);
    @(negedge clk);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 20'd0;
  endtask

  // Count edges after accept until done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [23:0] cap_digits;
    logic [5:0]  cap_blank;

    vecs[0] = '{20'd123456,  24'h123456, 1'b0, 6'b000000};
    vecs[1] = '{20'd999999,  24'h999999, 1'b0, 6'b000000};
    vecs[2] = '{20'd1000000, 24'h0F4240, 1'b1, 6'b100000};
    vecs[3] = '{20'd0,       24'h000000, 1'b0, 6'b111110};
    vecs[4] = '{20'd1048575, 24'h0FFFFF, 1'b1, 6'b100000};
    vecs[5] = '{20'd10,      24'h000010, 1'b0, 6'b111100};
    vecs[6] = '{20'd100000,  24'h100000, 1'b0, 6'b000000};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = 20'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_digits",   {8'd0, digits_out}, 32'd0);
    check("reset_overflow", {31'd0, overflow},  32'd0);
    check("reset_done",     {31'd0, done},      32'd0);
    check("reset_ready",    {31'd0, in_ready},  32'd1);
    check("reset_blank",    {26'd0, blank_out}, {26'd0, exp_blank(6'b111110)});

    // Table-driven conversions with latency check.
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].value);
      check("busy_not_ready", {31'd0, in_ready}, 32'd0);
      wait_done(lat);
      check("latency",  lat, 32'd21);
      check("digits",   {8'd0, digits_out}, {8'd0, vecs[i].digits});
      check("overflow", {31'd0, overflow},  {31'd0, vecs[i].ovf});
      check("blank",    {26'd0, blank_out}, {26'd0, exp_blank(vecs[i].blank_lz)});
      check("ready_in_done_cycle", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("digits_hold", {8'd0, digits_out}, {8'd0, vecs[i].digits});
    end

    // 42 accepted, then a request for 7 during SHIFT must be ignored.
    start(20'd42);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_value = 20'd7;
    check("ignored_req_not_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    in_value = 20'd0;
    ndone = 0;
    cap_digits = 24'hxxxxxx;
    cap_blank  = 6'bxxxxxx;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        cap_digits = digits_out;
        cap_blank  = blank_out;
      end
    end
    check("ignored_req_done_count", ndone, 32'd1);
    check("ignored_req_digits", {8'd0, cap_digits}, 32'h000042);
    check("ignored_req_blank",  {26'd0, cap_blank}, {26'd0, exp_blank(6'b111100)});

    // 500 accepted, reset asserted after shift edge 10.
    start(20'd500);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_digits",   {8'd0, digits_out}, 32'd0);
    check("midreset_overflow", {31'd0, overflow},  32'd0);
    check("midreset_done",     {31'd0, done},      32'd0);
    check("midreset_blank",    {26'd0, blank_out}, {26'd0, exp_blank(6'b111110)});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_ready", {31'd0, in_ready}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midreset_no_done", ndone, 32'd0);
    start(20'd7);
    wait_done(lat);
    check("after_reset_latency", lat, 32'd21);
    check("after_reset_digits",  {8'd0, digits_out}, 32'h000007);
    check("after_reset_ovf",     {31'd0, overflow},  32'd0);
    check("after_reset_blank",   {26'd0, blank_out}, {26'd0, exp_blank(6'b111110)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
